// File: rtl/conv2d_pkg.sv
// Shared types and default widths for the streaming 3x3 convolution engine.
// Used by conv2d_line_buffer and conv2d_stream_engine.
package conv2d_pkg;

  localparam int TAPS       = 9;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_IMG_W  = 128;
  localparam int DEF_IMG_H  = 128;
  localparam int DEF_ACC_W  = 24;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    DONE
  } state_e;

endpackage

// File: rtl/conv2d_line_buffer.sv
// One-row pixel delay: dout_o is the pixel written DEPTH enables ago.
// A single pointer serves as both read and write address.
module conv2d_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     ptr_q;

  assign dout_o = mem_q[ptr_q];

  // Pointer advances on every shift, wrapping at the end of the row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
    end
  end

  // Storage carries no reset; stale rows are masked by the engine
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 convolution, same-size output with internal zero padding.
// Optional macro CONV2D_RELU_EN clamps negative results to zero.
module conv2d_stream_engine
  import conv2d_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [TAPS*COEF_W-1:0] kernel,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int FCW = $clog2(IMG_W + 2);
  localparam int FW  = DATA_W + COEF_W + 5;
  localparam int SW  = (FW > ACC_W) ? FW : ACC_W;

  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FCW-1:0] FL_LAST  = FCW'(IMG_W);

  state_e                 state_q;
  logic [TAPS*COEF_W-1:0] kern_q;
  logic [CW-1:0]          col_q, cc_q;
  logic [RW-1:0]          row_q, cr_q;
  logic [FCW-1:0]         fcnt_q;
  logic                   busy_q, done_q;

  logic [DATA_W-1:0] win_q [3][3];
  logic s1_v_q, s1_last_q;
  logic s1_top_q, s1_bot_q, s1_lft_q, s1_rgt_q;
  logic [ACC_W-1:0] out_data_q;
  logic out_valid_q, out_last_q;

  logic adv, in_fire, fl_fire, fire, emit;
  logic in_last, fin, go;
  logic [DATA_W-1:0] pix, lb1_q, lb2_q, px_c;
  logic msk_c;
  logic signed [SW-1:0] acc_c;
  logic [ACC_W-1:0] res_c;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && (state_q == FILL || state_q == RUN);
  assign in_fire  = in_valid && in_ready;
  assign fl_fire  = (state_q == FLUSH) && adv && (fcnt_q <= FL_LAST);
  assign fire     = in_fire || fl_fire;
  assign pix      = fl_fire ? '0 : in_data;
  assign in_last  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign go       = (state_q == IDLE) && start;
  assign fin      = out_valid_q && out_ready && out_last_q;
  assign emit     = fl_fire || (in_fire && (state_q == RUN ||
                    (row_q == RW'(1) && col_q == CW'(1))));

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  conv2d_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (fire),
    .din_i  (pix),
    .dout_o (lb1_q)
  );

  conv2d_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb2 (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (fire),
    .din_i  (lb1_q),
    .dout_o (lb2_q)
  );

  // Frame control: input raster counters, flush counter, busy/done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      kern_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= FILL;
          kern_q  <= kernel;
          row_q   <= '0;
          col_q   <= '0;
          fcnt_q  <= '0;
          busy_q  <= 1'b1;
        end
        FILL, RUN: if (in_fire) begin
          if (row_q == RW'(1) && col_q == CW'(1)) state_q <= RUN;
          if (in_last) begin
            state_q <= FLUSH;
          end else if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        FLUSH: begin
          if (fl_fire) fcnt_q <= fcnt_q + FCW'(1);
          if (fin) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Window shift, centre tracking and the two-stage result pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cr_q        <= '0;
      cc_q        <= '0;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_top_q    <= 1'b0;
      s1_bot_q    <= 1'b0;
      s1_lft_q    <= 1'b0;
      s1_rgt_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_q[i][j] <= '0;
    end else begin
      if (go) begin
        cr_q <= '0;
        cc_q <= '0;
      end else if (emit) begin
        if (cc_q == COL_LAST) begin
          cc_q <= '0;
          cr_q <= cr_q + RW'(1);
        end else begin
          cc_q <= cc_q + CW'(1);
        end
      end
      if (adv) begin
        s1_v_q      <= emit;
        s1_top_q    <= (cr_q == '0);
        s1_bot_q    <= (cr_q == ROW_LAST);
        s1_lft_q    <= (cc_q == '0);
        s1_rgt_q    <= (cc_q == COL_LAST);
        s1_last_q   <= (cr_q == ROW_LAST) && (cc_q == COL_LAST);
        out_valid_q <= s1_v_q;
        if (s1_v_q) begin
          out_data_q <= res_c;
          out_last_q <= s1_last_q;
        end
      end
      if (fire) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= lb2_q;
        win_q[1][2] <= lb1_q;
        win_q[2][2] <= pix;
      end
    end
  end

  // Masked multiply-accumulate over the 3x3 window
  always_comb begin
    acc_c = '0;
    px_c  = '0;
    msk_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        msk_c = (i == 0 && s1_top_q) || (i == 2 && s1_bot_q) ||
                (j == 0 && s1_lft_q) || (j == 2 && s1_rgt_q);
        px_c  = msk_c ? '0 : win_q[i][j];
        acc_c = acc_c + SW'($signed({1'b0, px_c})) *
                SW'($signed(kern_q[(TAPS-1-(i*3+j))*COEF_W +: COEF_W]));
      end
    end
    res_c = acc_c[ACC_W-1:0];
`ifdef CONV2D_RELU_EN
    if (res_c[ACC_W-1]) res_c = '0;
`endif
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench: a 4x4 and a 128x128 engine share one stimulus path.
// Expected results come from a zero-padded reference convolution.
module tb_conv2d_stream_engine;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int sel = 0;
  logic        g_start = 1'b0;
  logic [71:0] g_kernel = '0;
  logic [7:0]  g_in_data = '0;
  logic        g_in_valid = 1'b0;
  logic        g_out_ready = 1'b0;
  logic        g_in_ready, g_out_valid, g_busy, g_done;
  logic [23:0] g_out_data;

  logic        a_in_ready, a_out_valid, a_busy, a_done;
  logic [23:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_busy, b_done;
  logic [23:0] b_out_data;

  conv2d_stream_engine #(.IMG_W(4), .IMG_H(4)) dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (sel == 0 ? g_start : 1'b0),
    .kernel   (g_kernel),
    .in_data  (g_in_data),
    .in_valid (sel == 0 ? g_in_valid : 1'b0),
    .in_ready (a_in_ready),
    .out_data (a_out_data),
    .out_valid(a_out_valid),
    .out_ready(sel == 0 ? g_out_ready : 1'b0),
    .busy     (a_busy),
    .done     (a_done)
  );

  conv2d_stream_engine #(.IMG_W(128), .IMG_H(128)) dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (sel == 1 ? g_start : 1'b0),
    .kernel   (g_kernel),
    .in_data  (g_in_data),
    .in_valid (sel == 1 ? g_in_valid : 1'b0),
    .in_ready (b_in_ready),
    .out_data (b_out_data),
    .out_valid(b_out_valid),
    .out_ready(sel == 1 ? g_out_ready : 1'b0),
    .busy     (b_busy),
    .done     (b_done)
  );

  assign g_in_ready  = (sel == 0) ? a_in_ready  : b_in_ready;
  assign g_out_valid = (sel == 0) ? a_out_valid : b_out_valid;
  assign g_out_data  = (sel == 0) ? a_out_data  : b_out_data;
  assign g_busy      = (sel == 0) ? a_busy      : b_busy;
  assign g_done      = (sel == 0) ? a_done      : b_done;

  int errors = 0;
  int checks = 0;
  int coef [9];
  int pmode = 0;
  logic [23:0] res [16384];

  function automatic int pix(input int idx);
    case (pmode)
      0:       return (idx + 1) & 255;
      1:       return 255;
      default: return ((idx * 37) ^ (idx >> 7)) & 255;
    endcase
  endfunction

  function automatic logic [23:0] model(input int w, input int h,
                                        input int r, input int c);
    int s;
    logic [23:0] v;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < h && c + dc >= 0 && c + dc < w)
          s += pix((r + dr) * w + c + dc) * coef[(dr + 1) * 3 + dc + 1];
    v = s[23:0];
`ifdef CONV2D_RELU_EN
    if (v[23]) v = '0;
`endif
    return v;
  endfunction

  task automatic run_frame(input string nm, input int s, input int rmode,
                           input bit mid_start, input bit end_start,
                           input int abort_at);
    int w, n, idx, ridx, cyc, limit, ndone, nd_abort;
    int en_cyc, fv_cyc, first_cyc, last_cyc, done_cyc;
    bit stall, aborted;
    logic [23:0] held, exp;
    sel = s;
    w = (s == 0) ? 4 : 128;
    n = w * w;
    for (int t = 0; t < 9; t++) g_kernel[(8 - t) * 8 +: 8] = 8'(coef[t]);
    g_in_valid = 1'b0;
    g_out_ready = 1'b0;
    @(negedge clk);
    g_start = 1'b1;
    @(negedge clk);
    g_start = 1'b0;
    #1;
    checks++;
    if (g_busy !== 1'b1)
      $display("FAIL %s busy_after_start: got %b need 1", nm, g_busy);
    if (g_busy !== 1'b1) errors++;
    idx = 0; ridx = 0; cyc = 0; ndone = 0; nd_abort = 0;
    en_cyc = -1; fv_cyc = -1; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    stall = 1'b0; aborted = 1'b0; held = '0;
    limit = 3 * n + 200;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      g_in_valid  = (idx < n);
      g_in_data   = 8'(pix(idx));
      g_out_ready = (rmode == 0) ? 1'b1 : cyc[0];
      g_start = (mid_start && idx == n / 2) ||
                (end_start && last_cyc >= 0 && last_cyc == cyc - 1);
      if (abort_at >= 0 && idx == abort_at) begin
        reset_n = 1'b0;
        g_in_valid = 1'b0;
        #1;
        checks++;
        if ({g_in_ready, g_out_valid, g_busy, g_done} !== 4'b0 ||
            g_out_data !== 24'd0) begin
          errors++;
          $display("FAIL %s abort_outputs: got rdy=%b vld=%b busy=%b done=%b data=%0h need all 0",
                   nm, g_in_ready, g_out_valid, g_busy, g_done, g_out_data);
        end
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (k == 10) reset_n = 1'b1;
          #1;
          if (g_done === 1'b1 || g_busy === 1'b1) nd_abort++;
        end
        checks++;
        if (nd_abort != 0) begin
          errors++;
          $display("FAIL %s abort_quiet: got %0d busy/done cycles need 0", nm, nd_abort);
        end
        aborted = 1'b1;
        break;
      end
      #1;
      if (stall) begin
        checks++;
        if (g_out_valid !== 1'b1 || g_out_data !== held) begin
          errors++;
          $display("FAIL %s stall_hold: got vld=%b data=%0h need vld=1 data=%0h",
                   nm, g_out_valid, g_out_data, held);
        end
      end
      stall = (g_out_valid === 1'b1) && !g_out_ready;
      held  = g_out_data;
      if (stall) begin
        checks++;
        if (g_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s in_ready_stall: got %b need 0", nm, g_in_ready);
        end
      end
      if (g_out_valid === 1'b1 && fv_cyc < 0) fv_cyc = cyc;
      if (g_in_valid && g_in_ready === 1'b1) begin
        if (idx == w + 1) en_cyc = cyc;
        idx++;
      end
      if (g_out_valid === 1'b1 && g_out_ready) begin
        checks++;
        if (ridx < n) begin
          exp = model(w, w, ridx / w, ridx % w);
          res[ridx] = g_out_data;
          if (g_out_data !== exp) begin
            errors++;
            $display("FAIL %s result[%0d]: got %0h need %0h", nm, ridx, g_out_data, exp);
          end
        end else begin
          errors++;
          $display("FAIL %s extra_result: got index %0d need < %0d", nm, ridx, n);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        ridx++;
      end
      if (g_done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 4) break;
    end
    g_start = 1'b0;
    g_in_valid = 1'b0;
    g_out_ready = 1'b0;
    if (!aborted) begin
      checks++;
      if (done_cyc < 0) begin
        errors++;
        $display("FAIL %s timeout: got no done in %0d cycles need done", nm, limit);
      end
      checks++;
      if (ridx != n) begin
        errors++;
        $display("FAIL %s result_count: got %0d need %0d", nm, ridx, n);
      end
      checks++;
      if (ndone != 1) begin
        errors++;
        $display("FAIL %s done_count: got %0d need 1", nm, ndone);
      end
      checks++;
      if (done_cyc != last_cyc + 1) begin
        errors++;
        $display("FAIL %s done_timing: got cycle %0d need %0d", nm, done_cyc, last_cyc + 1);
      end
      checks++;
      if (g_busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_after_done: got %b need 0", nm, g_busy);
      end
      if (rmode == 0) begin
        checks++;
        if (en_cyc < 0 || fv_cyc - en_cyc != 2) begin
          errors++;
          $display("FAIL %s latency: got %0d need 2", nm, fv_cyc - en_cyc);
        end
        checks++;
        if (last_cyc - first_cyc != n - 1) begin
          errors++;
          $display("FAIL %s throughput: got span %0d need %0d", nm, last_cyc - first_cyc, n - 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      checks++;
      if ({g_in_ready, g_out_valid, g_busy, g_done} !== 4'b0 ||
          g_out_data !== 24'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got rdy=%b vld=%b busy=%b done=%b data=%0h need all 0",
                 s, g_in_ready, g_out_valid, g_busy, g_done, g_out_data);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (g_busy !== 1'b0 || g_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b rdy=%b need 0 0", g_busy, g_in_ready);
    end
  endtask

  task automatic test_small();
    pmode = 0;
    coef = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_frame("small_ones", 0, 0, 1'b0, 1'b0, -1);
    checks++;
    if (res[0] !== 24'd14) begin
      errors++;
      $display("FAIL small_first: got %0d need 14", res[0]);
    end
    checks++;
    if (res[5] !== 24'd54) begin
      errors++;
      $display("FAIL small_centre: got %0d need 54", res[5]);
    end
  endtask

  task automatic test_signed_stall();
    pmode = 0;
    coef = '{-1, 2, -3, 4, -5, 6, -7, 8, -9};
    run_frame("small_signed", 0, 1, 1'b0, 1'b1, -1);
  endtask

  task automatic test_neg_centre();
    logic [23:0] e0, e15;
    pmode = 0;
    coef = '{0, 0, 0, 0, -1, 0, 0, 0, 0};
    run_frame("neg_centre", 0, 0, 1'b0, 1'b0, -1);
`ifdef CONV2D_RELU_EN
    e0 = 24'd0;
    e15 = 24'd0;
`else
    e0 = 24'hFFFFFF;
    e15 = 24'hFFFFF0;
`endif
    checks++;
    if (res[0] !== e0) begin
      errors++;
      $display("FAIL neg_first: got %0h need %0h", res[0], e0);
    end
    checks++;
    if (res[15] !== e15) begin
      errors++;
      $display("FAIL neg_last: got %0h need %0h", res[15], e15);
    end
  endtask

  task automatic test_const_start_in_run();
    pmode = 1;
    coef = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    run_frame("const255", 1, 0, 1'b1, 1'b0, -1);
    checks++;
    if (res[0] !== 24'd2295) begin
      errors++;
      $display("FAIL const_corner: got %0d need 2295", res[0]);
    end
    checks++;
    if (res[129] !== 24'd4080) begin
      errors++;
      $display("FAIL const_interior: got %0d need 4080", res[129]);
    end
    checks++;
    if (res[16383] !== 24'd2295) begin
      errors++;
      $display("FAIL const_last_corner: got %0d need 2295", res[16383]);
    end
  endtask

  task automatic test_back_to_back_toggle();
    pmode = 2;
    coef = '{3, -1, 2, 0, 5, -4, 1, 1, -2};
    run_frame("toggle128", 1, 1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_abort();
    pmode = 2;
    coef = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_frame("abort", 1, 0, 1'b0, 1'b0, 5000);
    pmode = 0;
    run_frame("after_abort", 0, 0, 1'b0, 1'b0, -1);
    checks++;
    if (res[5] !== 24'd54) begin
      errors++;
      $display("FAIL after_abort_centre: got %0d need 54", res[5]);
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_signed_stall();
    test_neg_centre();
    test_const_start_in_run();
    test_back_to_back_toggle();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv2d_stream_engine.md
CONV2D_STREAM_ENGINE -- requirements
Module: conv2d_stream_engine

Interface
REQ-001 Parameter DATA_W, default 8, pixel width (unsigned).
REQ-002 Parameter COEF_W, default 8, kernel coefficient width (two's complement).
REQ-003 Parameter IMG_W, default 128, image width in pixels (>=3).
REQ-004 Parameter IMG_H, default 128, image height in rows (>=3).
REQ-005 Parameter ACC_W, default 24, result width (two's complement).
REQ-006 Port list (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame.
- kernel  in  9*COEF_W  3x3 coefficients, row-major, k00 in MSBs; sampled on accepted start.
- in_data  in  DATA_W  raster-order pixel.
- in_valid  in  1  in_data valid.
- in_ready  out  1  engine accepts pixel this cycle.
- out_data  out  ACC_W  convolution result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts result.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse: last result accepted.

Function
REQ-007 FSM states: IDLE, FILL, RUN, FLUSH, DONE.
REQ-008 IDLE: start -> FILL; kernel latched; row/column counters cleared; start ignored in all other states.
REQ-009 FILL: accepts pixels with no output until row 0 and pixel (1,1) are stored; then RUN.
REQ-010 RUN: result for centre (r,c) computed once pixel (r+1,c+1) is accepted; last input pixel accepted -> FLUSH.
REQ-011 FLUSH: in_ready=0; remaining results (last row, last column) generated with zero-valued missing neighbours.
REQ-012 Output frame is same size (IMG_W x IMG_H results, raster order); out-of-image neighbours read as zero (zero padding generated internally, not supplied).
REQ-013 Handshake: transfer occurs when valid&&ready; out_data/out_valid held stable until out_ready; in_ready=0 whenever the output pipeline cannot advance.
REQ-014 Result = sum of 9 products pixel(unsigned, zero-extended) * coef(signed), accumulated at full precision, then truncated to ACC_W.
REQ-015 Latency: out_valid rises exactly 2 cycles after the enabling input pixel is accepted, given out_ready=1.
REQ-016 Sustained throughput: one pixel in and one result out per cycle when in_valid=out_ready=1.
REQ-017 Line storage: two rows of IMG_W pixels; write and read pointers wrap at IMG_W-1 -> 0.
REQ-018 Column counter wraps at IMG_W-1 and increments row counter; row counter ends at IMG_H-1.
REQ-019 DONE: done=1 for one cycle after final result transfer, busy=0 in the next cycle, -> IDLE.
REQ-020 start coincident with done: ignored; new start required in IDLE.

Reset
REQ-021 reset_n low: state=IDLE, counters=0, line storage contents don't-care, in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-022 reset_n asserted mid-frame aborts immediately; no done pulse; next frame requires new start.

Configuration
REQ-023 Macro CONV2D_RELU_EN defined: negative results clamped to 0 before output.
REQ-024 Macro CONV2D_RELU_EN undefined: result passed through signed and unmodified.

Structure
REQ-025 Shared package conv2d_pkg SHALL hold the FSM state enum, the kernel-tap count (9), and the default width constants.
REQ-026 Sub-module conv2d_line_buffer SHALL implement a single IMG_W x DATA_W row delay; two instances.

Verification
REQ-027 4x4 image 1..16, all-ones kernel -> first result 1+2+5+6=14, centre (1,1) = 54.
REQ-028 128x128 constant 255, kernel {1,2,1,2,4,2,1,2,1} -> interior results 4080, corner results 2295.
REQ-029 Kernel centre=-1, others 0, CONV2D_RELU_EN defined -> all results 0; macro undefined -> results = -pixel.
REQ-030 out_ready toggled 1/0 every cycle -> in_ready stalls, 16384 results emitted with no loss or duplication, out_data stable while stalled.
REQ-031 reset_n low at pixel 5000 -> all outputs 0, no done; a following 4x4 frame produces correct results.
REQ-032 start pulsed during RUN -> ignored; exactly one done after IMG_W*IMG_H results.
